// File: rtl/demux_lane_collector_if.sv
// rtl/demux_lane_collector_if.sv - demux sample inputs and per-lane word outputs
interface demux_lane_collector_if #(
    parameter int W = 8
);
    localparam int CW = $clog2(W);

    logic              en;
    logic [1:0]        s;
    logic [3:0]        y;
    logic [3:0]        ready;
    logic [3:0]        clr_ovf;
    logic [4*W-1:0]    word;
    logic [3:0]        valid;
    logic [3:0]        ovf;
    logic [4*CW-1:0]   cnt;

    modport master (
        output en, s, y, ready, clr_ovf,
        input  word, valid, ovf, cnt
    );

    modport slave (
        input  en, s, y, ready, clr_ovf,
        output word, valid, ovf, cnt
    );
endinterface

// File: rtl/demux_lane_collector.sv
// rtl/demux_lane_collector.sv - assembles demux lane bits into W-bit words per lane
module demux_lane_collector #(
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    demux_lane_collector_if.slave  bus
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [W-1:0]  sh     [4];
    logic [CW-1:0] cnt_r  [4];
    logic [W-1:0]  word_r [4];
    logic [3:0]    valid_r;
    logic [3:0]    ovf_r;

    logic [3:0]    cap;
    logic [3:0]    done;
    logic          bit_in;

    always_comb begin
        cap    = '0;
        done   = '0;
        bit_in = bus.y[bus.s];
        for (int n = 0; n < 4; n++) begin
            cap[n]  = bus.en && (bus.s == 2'(n));
            done[n] = cap[n] && (cnt_r[n] == LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                sh[n]     <= '0;
                cnt_r[n]  <= '0;
                word_r[n] <= '0;
            end
            valid_r <= '0;
            ovf_r   <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (cap[n]) begin
                    sh[n]    <= {bit_in, sh[n][W-1:1]};
                    cnt_r[n] <= done[n] ? '0 : cnt_r[n] + 1'b1;
                end

                // A completed word only lands if the holding register is empty or draining this edge.
                if (done[n] && (!valid_r[n] || bus.ready[n])) begin
                    word_r[n]  <= {bit_in, sh[n][W-1:1]};
                    valid_r[n] <= 1'b1;
                end else if (valid_r[n] && bus.ready[n]) begin
                    valid_r[n] <= 1'b0;
                end

                if (done[n] && valid_r[n] && !bus.ready[n])
                    ovf_r[n] <= 1'b1;
                else if (bus.clr_ovf[n])
                    ovf_r[n] <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_out
        assign bus.word[g*W +: W]   = word_r[g];
        assign bus.cnt[g*CW +: CW]  = cnt_r[g];
    end
    assign bus.valid = valid_r;
    assign bus.ovf   = ovf_r;
endmodule

// File: doc/demux_lane_collector.md
# demux_lane_collector

Downstream consumer of the 1-to-4 bit demultiplexer. Samples the demux lane outputs together with its enable and select, assembles the bits steered to each lane into W-bit words (LSB first), and presents each completed word on a per-lane valid/ready output. Lanes are fully independent. The demux has no backpressure, so a word that cannot be stored is dropped and flagged.

## Interface
- W, default 8: word width per lane (2..32).
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  demux enable; a bit is present this cycle when high.
- s  input  2  demux select; identifies the lane carrying the bit.
- y  input  4  demux outputs; the bit value is y[s].
- ready  input  4  per-lane consumer ready.
- clr_ovf  input  4  per-lane synchronous clear of the overflow flag.
- word  output  4*W  lane n word at bits [n*W +: W].
- valid  output  4  per-lane word-available.
- ovf  output  4  per-lane sticky overflow.
- cnt  output  4*$clog2(W)  per-lane count of bits assembled so far (debug/observability).

## Operation
- Per lane n: W-bit shift register sh[n], bit counter cnt[n] (0..W-1), holding register word[n], flag valid[n], flag ovf[n].
- Bit capture: on an edge with en=1, only lane s is updated. The new bit b=y[s] is shifted in at the MSB end: sh <= {b, sh[W-1:1]}. After W bits, the first bit received sits at bit 0. Lines y[m] for m≠s are ignored. With en=0, no lane changes.
- Completion: when cnt[s]=W-1 and a bit is captured:
  - word[s] <= {b, sh[s][W-1:1]}.
  - cnt[s] <= 0.
  - sh[s] is don't-care for the next word.
- Store rule at completion:
  - If valid=0, or valid=1 and ready=1 on the same edge: the new word is loaded and valid stays or becomes 1.
  - If valid=1 and ready=0: the new word is dropped, word and valid are unchanged, and ovf is set to 1.
- Handshake: a transfer occurs on an edge with valid[n]=1 and ready[n]=1. After the transfer, valid[n] goes to 0 unless a new word completes on the same edge. ready with valid=0 has no effect.
- word[n] is stable while valid[n]=1 and no transfer has occurred.
- Overflow:
  - ovf[n] is sticky until clr_ovf[n]=1.
  - If a clear and a new overflow occur on the same edge, set wins and ovf stays 1.
  - clr_ovf does not affect data path state.
- Reset (async, any time, including mid-word):
  - sh=0, cnt=0, word=0, valid=0, ovf=0 for all lanes, immediately.
  - Partial words are discarded.
  - After rst deasserts, the first captured bit on a lane starts a new word.
- No combinational path from inputs to outputs; all outputs are registers.

## Timing
- Bit-to-count: cnt[s] reflects a captured bit the cycle after the capture edge.
- Latency: valid[n] rises on the edge that samples the W-th bit, so it is visible 1 cycle after that bit is presented.
- Back-to-back: a lane receiving bits every cycle completes a word every W cycles. A consumer holding ready=1 continuously never overflows.
- Throughput per lane is at most 1 bit per cycle. Aggregate is 1 bit per cycle, limited by the single-lane demux.
- ready and clr_ovf are sampled only on rising edges.

## Test plan
- Reset: assert rst mid-cycle after 3 bits on lane 2 -> all outputs 0 immediately. Then 8 bits on lane 2 -> exactly one word, no stale bits.
- Single word (W=8): en=1, s=1, with y[1] sequence 1,0,1,1,0,0,1,0 over 8 cycles; y[0], y[2], y[3] toggling randomly; ready=0.
  - One cycle after the 8th bit: valid=4'b0010 and word[1]=8'h4D.
  - Other lanes stay at cnt=0.
- Interleaved lanes: alternate s=0 (all 1s) and s=3 (all 0s) for 16 cycles, with en=0 gaps inserted.
  - Required: word[0]=8'hFF, word[3]=8'h00.
  - Both valid bits set on their respective 8th-bit edges.
- Overflow: lane 0 valid holding 8'hAA, ready[0]=0, complete a second word 8'h55.
  - Required: word[0] stays 8'hAA and ovf[0]=1.
  - Then clr_ovf[0]=1 for 1 cycle -> ovf[0]=0.
  - Repeat with clr_ovf and the overflow on the same edge -> ovf[0] stays 1.
- Simultaneous transfer and completion: lane 2 valid with 8'h0F, ready[2]=1 on the edge of the next word's 8th bit.
  - Required: word[2] becomes the new word, valid[2] stays 1, ovf[2]=0.
- Streaming: lane 3 receives a random bit every cycle for 800 cycles with ready[3]=1.
  - Required: 100 words matching the scoreboard and ovf[3]=0.
